nv_nvdla_cacc_dlv_rcv: RTL

Receive side of the CACC delivery interface. Captures final accumulator vectors pushed by the CACC calculator on `dlv_valid`/`dlv_data`/`dlv_pd`, which carries no backpressure. Buffers them in a small FIFO and drains each vector to the SDP-facing port as `DLV_WIDTH/OUT_WIDTH` narrower beats under a valid/ready handshake. Flow control toward the calculator is credit-based: one credit pulse is returned per freed entry.

---
 rtl/nv_nvdla_cacc_dlv_pkg.sv | 27 ++
 rtl/nv_nvdla_cacc_dlv_rcv_if.sv | 29 ++
 rtl/nv_nvdla_cacc_dlv_fifo.sv | 55 +++++
 rtl/nv_nvdla_cacc_dlv_rcv.sv | 133 +++++++++++++
 4 files changed

// File: rtl/nv_nvdla_cacc_dlv_pkg.sv
// Shared definitions for the CACC delivery receive path: pd bit positions,
// entry layout, default widths and beat FSM states.
package nv_nvdla_cacc_dlv_pkg;

    localparam int DLV_WIDTH_DEF = 1024;
    localparam int OUT_WIDTH_DEF = 256;
    localparam int DEPTH_DEF     = 8;

    localparam int DLV_PD_STRIPE_END = 0;
    localparam int DLV_PD_LAYER_END  = 1;

    localparam int OUT_PD_LAST       = 0;
    localparam int OUT_PD_STRIPE_END = 1;
    localparam int OUT_PD_LAYER_END  = 2;

    // FIFO entries are stored flat as {pd, data}; this is the default-width view.
    typedef struct packed {
        logic [1:0]               pd;
        logic [DLV_WIDTH_DEF-1:0] data;
    } dlv_entry_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } beat_state_t;

endpackage

// File: rtl/nv_nvdla_cacc_dlv_rcv_if.sv
// Delivery-in / beat-out bundle for nv_nvdla_cacc_dlv_rcv.
interface nv_nvdla_cacc_dlv_rcv_if
    import nv_nvdla_cacc_dlv_pkg::*;
#(
    parameter int DLV_WIDTH = DLV_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF
);
    logic                 dlv_valid;
    logic                 dlv_mask;
    logic [DLV_WIDTH-1:0] dlv_data;
    logic [1:0]           dlv_pd;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic [2:0]           out_pd;
    logic                 dlv_credit_vld;
    logic                 layer_done;
    logic                 dlv_overflow;

    modport slave (
        input  dlv_valid, dlv_mask, dlv_data, dlv_pd, out_ready,
        output out_valid, out_data, out_pd, dlv_credit_vld, layer_done, dlv_overflow
    );

    modport master (
        output dlv_valid, dlv_mask, dlv_data, dlv_pd, out_ready,
        input  out_valid, out_data, out_pd, dlv_credit_vld, layer_done, dlv_overflow
    );
endinterface

// File: rtl/nv_nvdla_cacc_dlv_fifo.sv
// Entry FIFO for the delivery receiver: storage, pointers, occupancy and
// sticky overflow. A write into a full FIFO is still taken if a pop frees a slot.
module nv_nvdla_cacc_dlv_fifo
    import nv_nvdla_cacc_dlv_pkg::*;
#(
    parameter int WIDTH = DLV_WIDTH_DEF + 2,
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wr_entry,
    output logic [WIDTH-1:0] o_rd_entry,
    output logic [AW:0]      o_count,
    output logic             o_accept,
    output logic             o_overflow
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_overflow;
    logic             w_full;

    // count never exceeds DEPTH, so its MSB alone marks full
    assign w_full     = r_count[AW];
    assign o_accept   = i_wr & (~w_full | i_pop);
    assign o_rd_entry = r_mem[r_rd_ptr];
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

    always_ff @(posedge i_clk) begin
        if (o_accept) r_mem[r_wr_ptr] <= i_wr_entry;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (o_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({o_accept, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (i_wr & ~o_accept) r_overflow <= 1'b1;
        end
    end
endmodule

// File: rtl/nv_nvdla_cacc_dlv_rcv.sv
// CACC delivery receiver: buffers pushed vectors and drains them as narrow beats,
// returning one credit per freed entry. NVDLA_CACC_DLV_PERF_EN adds the stall counter.
//
// state   | meaning
// IDLE    | FIFO empty, beat held at 0
// SEND    | entries pending, beat advances on each handshake
module nv_nvdla_cacc_dlv_rcv
    import nv_nvdla_cacc_dlv_pkg::*;
#(
    parameter int DLV_WIDTH = DLV_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF,
    parameter int DEPTH     = DEPTH_DEF
) (
    input  logic                   nvdla_core_clk,
    input  logic                   nvdla_core_rst,
    nv_nvdla_cacc_dlv_rcv_if.slave dlv_if
`ifdef NVDLA_CACC_DLV_PERF_EN
    ,
    output logic [31:0]            dp2reg_dlv_stall_count
`endif
);
    localparam int BEATS = DLV_WIDTH / OUT_WIDTH;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);

    logic [DLV_WIDTH+1:0] w_rd_entry;
    logic [DLV_WIDTH-1:0] w_rd_data;
    logic [1:0]           w_rd_pd;
    logic [AW:0]          w_count;
    logic                 w_accept;
    logic                 w_out_valid;
    logic                 w_last;
    logic                 w_hs;
    logic                 w_pop;
    logic [OUT_WIDTH-1:0] w_beat_data [BEATS];

    beat_state_t          r_state;
    logic [BW-1:0]        r_beat;
    logic                 r_credit;
    logic                 r_layer_done;

    nv_nvdla_cacc_dlv_fifo #(
        .WIDTH (DLV_WIDTH + 2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk      (nvdla_core_clk),
        .i_rst      (nvdla_core_rst),
        .i_wr       (dlv_if.dlv_valid & dlv_if.dlv_mask),
        .i_pop      (w_pop),
        .i_wr_entry ({dlv_if.dlv_pd, dlv_if.dlv_data}),
        .o_rd_entry (w_rd_entry),
        .o_count    (w_count),
        .o_accept   (w_accept),
        .o_overflow (dlv_if.dlv_overflow)
    );

    assign w_rd_data   = w_rd_entry[DLV_WIDTH-1:0];
    assign w_rd_pd     = w_rd_entry[DLV_WIDTH+1:DLV_WIDTH];
    assign w_out_valid = (w_count != '0);
    assign w_last      = (r_beat == LAST_BEAT);
    assign w_hs        = w_out_valid & dlv_if.out_ready;
    assign w_pop       = w_hs & w_last;

    // beat 0 carries the LSBs of the vector
    for (genvar g = 0; g < BEATS; g++) begin : g_beat
        assign w_beat_data[g] = w_rd_data[g*OUT_WIDTH +: OUT_WIDTH];
    end

    assign dlv_if.out_valid      = w_out_valid;
    assign dlv_if.out_data       = w_beat_data[r_beat];
    assign dlv_if.dlv_credit_vld = r_credit;
    assign dlv_if.layer_done     = r_layer_done;

    always_comb begin
        dlv_if.out_pd = 3'b000;
        if (w_out_valid) begin
            dlv_if.out_pd[OUT_PD_LAST]       = w_last;
            dlv_if.out_pd[OUT_PD_STRIPE_END] = w_last & w_rd_pd[DLV_PD_STRIPE_END];
            dlv_if.out_pd[OUT_PD_LAYER_END]  = w_last & w_rd_pd[DLV_PD_LAYER_END];
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            r_state      <= ST_IDLE;
            r_beat       <= '0;
            r_credit     <= 1'b0;
            r_layer_done <= 1'b0;
        end else begin
            r_credit     <= w_pop;
            r_layer_done <= w_pop & w_rd_pd[DLV_PD_LAYER_END];
            case (r_state)
                ST_IDLE: begin
                    r_beat <= '0;
                    if (w_accept) r_state <= ST_SEND;
                end
                ST_SEND: begin
                    if (w_pop) begin
                        r_beat <= '0;
                        if ((w_count == CNT_ONE) && !w_accept) r_state <= ST_IDLE;
                    end else if (w_hs) begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_beat  <= '0;
                end
            endcase
        end
    end

`ifdef NVDLA_CACC_DLV_PERF_EN
    logic [31:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall                = w_out_valid & ~dlv_if.out_ready;
    assign dp2reg_dlv_stall_count = r_stall_cnt;

    // the layer_done cycle restarts the count, keeping a stall seen in that cycle
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            r_stall_cnt <= '0;
        end else if (r_layer_done) begin
            r_stall_cnt <= {31'd0, w_stall};
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end
`endif
endmodule
